// File: rtl/wb_stream_writer.sv
// wb_stream_writer: Wishbone B4 burst master that drains a 32-bit valid/ready
// word stream into memory. A base address and word count are programmed with
// a start pulse; words are buffered in a small FIFO and written out as
// incrementing-address bursts of at most BURST_LEN beats.
module wb_stream_writer #(
   parameter int AW         = 32,
   parameter int BURST_LEN  = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start_i,
   input  logic [AW-1:0] base_adr_i,
   input  logic [23:0]   length_i,
   output logic          busy_o,
   output logic          done_o,
   input  logic [31:0]   s_data_i,
   input  logic          s_valid_i,
   output logic          s_ready_o,
   output logic [AW-1:0] wb_adr_o,
   output logic [31:0]   wb_dat_o,
   output logic [3:0]    wb_sel_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic          wb_ack_i
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(BURST_LEN) + 1;
   localparam logic [23:0]   BURST_LEN_W = 24'(BURST_LEN);
   localparam logic [CW-1:0] DEPTH_W     = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] WORD_MASK   = ~(AW'(3));
   localparam logic [AW-1:0] WORD_STEP   = AW'(4);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_r;
   logic [31:0]     mem_r [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [23:0]     accepted_r;
   logic [23:0]     len_r;
   logic [23:0]     rem_r;
   logic [AW-1:0]   cur_adr_r;
   logic [BW-1:0]   burst_left_r;

   logic            push_s;
   logic            pop_s;
   logic            start_go_s;
   logic            last_word_s;
   logic            final_beat_s;
   logic            done_set_s;
   logic            busy_nxt_s;
   logic [CW-1:0]   count_nxt_s;
   logic [23:0]     accepted_nxt_s;
   logic [23:0]     len_nxt_s;
   logic [23:0]     beats_s;
   logic            burst_ok_s;
   logic [31:0]     head_s;
   logic [31:0]     head_nxt_s;

   assign wb_bte_o     = 2'b00;
   assign push_s       = s_valid_i & s_ready_o;
   assign pop_s        = (state_r == ST_BURST) & wb_stb_o & wb_ack_i;
   assign start_go_s   = (state_r == ST_IDLE) & start_i;
   assign last_word_s  = (rem_r == 24'd1);
   assign final_beat_s = (burst_left_r == BW'(1));
   assign head_s       = mem_r[rd_ptr_r];
   assign head_nxt_s   = mem_r[rd_ptr_r + PW'(1)];

   // Next-cycle values that the registered stream ready and busy flag depend on.
   always_comb begin
      count_nxt_s    = count_r + CW'(push_s) - CW'(pop_s);
      len_nxt_s      = len_r;
      accepted_nxt_s = accepted_r + 24'(push_s);
      done_set_s     = (pop_s & last_word_s) | ((state_r == ST_DONE) & ~done_o);
      busy_nxt_s     = busy_o;
      if (start_go_s) begin
         len_nxt_s      = length_i;
         accepted_nxt_s = 24'd0;
         busy_nxt_s     = 1'b1;
      end else if (done_set_s) begin
         busy_nxt_s     = 1'b0;
      end else begin
         busy_nxt_s     = busy_o;
      end
   end

   // Size of the next burst and whether the FIFO already holds all of its words.
   always_comb begin
      beats_s    = BURST_LEN_W;
      burst_ok_s = 1'b0;
      if (rem_r < BURST_LEN_W) begin
         beats_s = rem_r;
      end else begin
         beats_s = BURST_LEN_W;
      end
      burst_ok_s = (24'(count_r) >= beats_s);
   end

   // FIFO storage; entries are not cleared, the pointers define what is valid.
   always_ff @(posedge wb_clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= s_data_i;
      end
   end

   // FIFO pointers, fill count and stream-side accept bookkeeping.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         accepted_r <= 24'd0;
         len_r      <= 24'd0;
         s_ready_o  <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r    <= count_nxt_s;
         accepted_r <= accepted_nxt_s;
         len_r      <= len_nxt_s;
         s_ready_o  <= busy_nxt_s & (count_nxt_s < DEPTH_W) & (accepted_nxt_s < len_nxt_s);
      end
   end

   // Transfer FSM and registered Wishbone master outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r      <= ST_IDLE;
         rem_r        <= 24'd0;
         cur_adr_r    <= '0;
         burst_left_r <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         wb_adr_o     <= '0;
         wb_dat_o     <= 32'd0;
         wb_sel_o     <= 4'h0;
         wb_we_o      <= 1'b0;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_cti_o     <= 3'b000;
      end else begin
         busy_o <= busy_nxt_s;
         done_o <= done_set_s;
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  cur_adr_r <= base_adr_i & WORD_MASK;
                  rem_r     <= length_i;
                  if (length_i == 24'd0) begin
                     state_r <= ST_DONE;
                  end else begin
                     state_r <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (burst_ok_s) begin
                  state_r      <= ST_BURST;
                  burst_left_r <= beats_s[BW-1:0];
                  wb_cyc_o     <= 1'b1;
                  wb_stb_o     <= 1'b1;
                  wb_we_o      <= 1'b1;
                  wb_sel_o     <= 4'hF;
                  wb_adr_o     <= cur_adr_r;
                  wb_dat_o     <= head_s;
                  wb_cti_o     <= (beats_s == 24'd1) ? 3'b111 : 3'b010;
               end
            end
            ST_BURST: begin
               if (pop_s) begin
                  rem_r        <= rem_r - 24'd1;
                  cur_adr_r    <= cur_adr_r + WORD_STEP;
                  burst_left_r <= burst_left_r - BW'(1);
                  if (final_beat_s) begin
                     // Drop the cycle on the final ack; WAIT guarantees an idle gap.
                     wb_cyc_o <= 1'b0;
                     wb_stb_o <= 1'b0;
                     wb_we_o  <= 1'b0;
                     wb_sel_o <= 4'h0;
                     wb_cti_o <= 3'b000;
                     state_r  <= last_word_s ? ST_DONE : ST_WAIT;
                  end else begin
                     wb_adr_o <= wb_adr_o + WORD_STEP;
                     wb_dat_o <= head_nxt_s;
                     wb_cti_o <= (burst_left_r == BW'(2)) ? 3'b111 : 3'b010;
                  end
               end
            end
            ST_DONE: begin
               // Zero-length transfers arrive with done_o low and pulse it here.
               if (done_o) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/wb_stream_writer.md
# wb_stream_writer

Wishbone B4 burst master that drains a 32-bit valid/ready word stream into memory through the `wb_hyper` data slave. The main use is writing Boson pixel data into HyperRAM. Software or a control FSM programs a base address and a word count, then pulses start. The block buffers incoming words in a small FIFO and emits incrementing-address bursts, one word per acknowledged beat.

## Interface
- `AW`, 32, Wishbone address width.
- `BURST_LEN`, 4, maximum beats per burst (power of two, 1..32).
- `FIFO_DEPTH`, 16, input FIFO depth in words (power of two, ≥ `BURST_LEN`).
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: one-cycle pulse that begins a transfer; ignored while `busy_o`=1.
- `base_adr_i` in AW: byte address of the first word; bits [1:0] are ignored (treated as 0).
- `length_i` in 24: number of 32-bit words to transfer.
- `busy_o` out 1: transfer in progress.
- `done_o` out 1: one-cycle pulse when a transfer completes.
- `s_data_i` in 32: stream data.
- `s_valid_i` in 1: stream data valid.
- `s_ready_o` out 1: block accepts `s_data_i` when `s_valid_i`=1 and `s_ready_o`=1.
- `wb_adr_o` out AW: Wishbone address.
- `wb_dat_o` out 32: Wishbone write data.
- `wb_sel_o` out 4: byte selects.
- `wb_we_o` out 1: write enable.
- `wb_cyc_o` out 1: bus cycle.
- `wb_stb_o` out 1: strobe.
- `wb_cti_o` out 3: cycle type identifier.
- `wb_bte_o` out 2: burst type extension; constant 2'b00 (linear).
- `wb_ack_i` in 1: slave acknowledge.

## Operation
- FSM states and transitions:
  - IDLE: on `start_i`, latch base and length, move to WAIT. If `length_i`=0, move to DONE instead.
  - WAIT: `beats` = min(`BURST_LEN`, remaining). Move to BURST once the FIFO count ≥ `beats`.
  - BURST: drive one beat per `wb_ack_i`. On the final ack, return to WAIT if remaining > 0, else go to DONE.
  - DONE: pulse `done_o` for one cycle, then return to IDLE.
- Bus signals during BURST:
  - `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=1 and `wb_sel_o`=4'hF.
  - `wb_dat_o` = FIFO head; the FIFO pops on each ack.
  - `wb_adr_o` starts at the current address and increments by 4 per ack.
  - `wb_cti_o`=3'b010 on every beat except the last, which is 3'b111. A single-beat burst is 3'b111 only.
- Stream side:
  - `s_ready_o` = `busy_o` & FIFO not full & (words accepted < length).
  - Words beyond the programmed length are never accepted.
  - A simultaneous push and pop keeps the FIFO count unchanged.
- Address arithmetic is modulo 2^AW; wrap-around is silent. There is no page or boundary splitting.
- `start_i` while busy: ignored, no state change.
- Reset, including mid-burst: FSM goes to IDLE, the FIFO is flushed and the counters are cleared. The Wishbone cycle is abandoned, with `wb_cyc_o` low after the reset edge.

## Timing
- Reset values: all outputs are 0, including `wb_cti_o`=3'b000 and `wb_bte_o`=2'b00.
- All outputs are registered.
- `busy_o` rises on the cycle after `start_i` and falls in the same cycle that `done_o` pulses.
- A pushed word is visible in the FIFO count one cycle after the push edge.
- `wb_cyc_o`/`wb_stb_o` assert one cycle after WAIT sees a sufficient count.
- Zero-wait-state acks are supported: acks on consecutive cycles give back-to-back beats. `wb_adr_o`, `wb_dat_o` and `wb_cti_o` update on the ack edge while `wb_stb_o` stays high.
- Ack wait states: `wb_stb_o` and all bus outputs are held stable until `wb_ack_i`.
- `wb_cyc_o`/`wb_stb_o` fall on the edge that samples the final ack.
- There is at least one idle cycle (`wb_cyc_o`=0) between bursts.
- `done_o` is high one cycle after the final ack of the transfer.
- Zero length: `done_o` two cycles after `start_i`; `wb_cyc_o` never asserts.

## Test plan
- Single word: base 0x100, length 1, data 0x12345678 → one beat at `wb_adr_o`=0x100 with `wb_cti_o`=111 and `wb_dat_o`=0x12345678; `done_o` pulses once; readback matches.
- One full burst: base 0, length 4, words 0x01020304, 0x05060708, 0x090a0b0c, 0x0d0e0f00 → addresses 0x0/0x4/0x8/0xC with cti 010/010/010/111; `read_burst_comp` matches.
- Split transfer: base 0x40, length 6 → a burst of 4 at 0x40..0x4C, an idle cycle, then a burst of 2 at 0x50/0x54 with cti 010/111; the 7th stream word is refused (`s_ready_o`=0).
- Backpressure and gaps: random ack wait states 0–8 and random `s_valid_i` gaps, length 32 → bus outputs stable while stalled and data order intact. With acks withheld, `s_ready_o` drops after 16 words are buffered.
- Reset mid-burst: assert `wb_rst_i` during beat 2 → `wb_cyc_o`, `busy_o` and `s_ready_o` are 0 after the edge. A subsequent start with length 4 completes normally from the new base.
- Edge cases: `length_i`=0 → `done_o` with no bus cycle. A `start_i` pulse while busy is ignored and the transfer count is unchanged.
